// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding common to rx and tx, and the
// default oversampling ratio with its tick-counter width.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int TICK_W_DEF     = $clog2(OVERSAMPLE_DEF);

    function automatic int tick_w(input int oversample);
        return $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: baud tick and serial line in, received byte and the
// done/valid/ack handshake toward the consumer.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud;
    logic                 rx;
    logic                 rx_ack;
    logic [DATA_BITS-1:0] d_out;
    logic                 rx_done;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output baud, rx, rx_ack,
        input  d_out, rx_done, rx_valid, frame_err, overrun
    );

    modport slave (
        input  baud, rx, rx_ack,
        output d_out, rx_done, rx_valid, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the idle-high serial line, plus the synchronized
// value captured at the previous baud tick for start-edge detection.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic rx,
    output logic rxs,
    output logic rxs_prev
);
    logic meta_q, meta_d;
    logic rxs_q, rxs_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx;
        rxs_d  = meta_q;
        prev_d = tick ? rxs_q : prev_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            rxs_q  <= rxs_d;
            prev_q <= prev_d;
        end
    end

    assign rxs      = rxs_q;
    assign rxs_prev = prev_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled LSB-first framing with mid-bit sampling, delivering
// each byte with a one-clock done pulse and a sticky valid/ack handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input logic      clk,
    input logic      rst_n,
    uart_rx_if.slave bus
);
    localparam int S_W = tick_w(OVERSAMPLE);
    localparam int N_W = $clog2(DATA_BITS);
    localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    logic rxs, rxs_prev;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (bus.baud),
        .rx       (bus.rx),
        .rxs      (rxs),
        .rxs_prev (rxs_prev)
    );

    uart_state_e          state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] d_out_q, d_out_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        d_out_d = d_out_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (bus.rx_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        if (bus.baud) begin
            case (state_q)
                IDLE: begin
                    // Edge, not level: a held-low break line cannot restart a frame.
                    if (rxs_prev && !rxs) begin
                        s_d     = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (s_q == S_HALF) begin
                        if (!rxs) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
                DATA: begin
                    if (s_q == S_LAST) begin
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        s_d     = '0;
                        if (n_q == N_LAST) state_d = STOP;
                        else               n_d     = n_q + N_W'(1);
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
                STOP: begin
                    // A simultaneous ack consumes the old byte, so it cannot overrun.
                    if (s_q == S_LAST) begin
                        d_out_d = shift_q;
                        done_d  = 1'b1;
                        ferr_d  = ~rxs;
                        valid_d = 1'b1;
                        ovr_d   = ovr_q | (valid_q & ~bus.rx_ack);
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            d_out_q <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            d_out_q <= d_out_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.d_out     = d_out_q;
    assign bus.rx_done   = done_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are generated at line level, and a frame-level
// model predicts the delivered byte, flags and handshake on every clock.
module tb_uart_rx;
    localparam int DB = 8;
    localparam int OS = 16;
    localparam int P  = 4;   // clocks per baud tick

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          tick;
        logic [DB-1:0] data;
        logic        stop;
    } frame_t;

    frame_t exp_q[$];
    int     tick_n   = -1;
    int     n_chk    = 0;
    int     n_pass   = 0;
    int     done_cnt = 0;
    bit     cmp_on   = 1'b0;
    bit     ack_run  = 1'b0;

    logic [DB-1:0] m_dout  = '0;
    logic          m_done  = 1'b0;
    logic          m_valid = 1'b0;
    logic          m_ferr  = 1'b0;
    logic          m_ovr   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Baud tick generator; tick_n holds the index of the tick about to be sampled.
    initial begin
        int bcnt;
        bcnt = 0;
        bus.baud = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bcnt++;
            if (bcnt == P) begin
                bcnt = 0;
                bus.baud = 1'b1;
                tick_n++;
            end else begin
                bus.baud = 1'b0;
            end
        end
    end

    // Frame-level model: a frame completes on its predicted mid-stop-bit tick.
    always @(posedge clk) begin : model
        frame_t f;
        if (!rst_n) begin
            exp_q.delete();
            m_dout  <= '0;
            m_done  <= 1'b0;
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
        end else if (bus.baud && exp_q.size() > 0 && exp_q[0].tick == tick_n) begin
            f = exp_q.pop_front();
            m_dout  <= f.data;
            m_done  <= 1'b1;
            m_ferr  <= ~f.stop;
            m_valid <= 1'b1;
            m_ovr   <= m_ovr | (m_valid & ~bus.rx_ack);
        end else begin
            m_done <= 1'b0;
            if (bus.rx_ack && m_valid) begin
                m_valid <= 1'b0;
                m_ovr   <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.rx_done === 1'b1) done_cnt++;
        if (cmp_on) begin
            chk("rx_done",   32'(bus.rx_done),   32'(m_done));
            chk("d_out",     32'(bus.d_out),     32'(m_dout));
            chk("rx_valid",  32'(bus.rx_valid),  32'(m_valid));
            chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
            chk("overrun",   32'(bus.overrun),   32'(m_ovr));
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (bus.baud !== 1'b1);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Line fall is seen one tick late through the synchronizer; mid-start is
    // OS/2 ticks after that, and mid-stop a further (DB+1) bit periods on.
    task automatic send_frame(input logic [DB-1:0] data, input logic stop);
        frame_t f;
        wait_tick();
        f.tick = tick_n + 1 + OS / 2 + (DB + 1) * OS;
        f.data = data;
        f.stop = stop;
        exp_q.push_back(f);
        #1 bus.rx = 1'b0;
        for (int i = 0; i < DB; i++) begin
            repeat (OS) wait_tick();
            #1 bus.rx = data[i];
        end
        repeat (OS) wait_tick();
        #1 bus.rx = stop;
        repeat (OS - 1) wait_tick();
    endtask

    task automatic idle(input int g);
        repeat (g) begin
            wait_tick();
            #1 bus.rx = 1'b1;
        end
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 bus.rx_ack = 1'b1;
        @(posedge clk);
        #1 bus.rx_ack = 1'b0;
    endtask

    task automatic random_phase(input int nframes);
        logic [DB-1:0] d;
        logic          st;
        int            g;
        ack_run = 1'b1;
        fork
            begin
                for (int k = 0; k < nframes; k++) begin
                    d  = DB'($urandom);
                    st = ($urandom_range(0, 3) != 0);
                    send_frame(d, st);
                    g = $urandom_range(0, 3);
                    if (!st && g == 0) g = 1;
                    idle(g);
                end
                ack_run = 1'b0;
            end
            begin
                while (ack_run) begin
                    @(posedge clk);
                    #1 bus.rx_ack = ($urandom_range(0, 7) == 0);
                end
                bus.rx_ack = 1'b0;
            end
        join
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        bus.rx = 1'b1;
        bus.rx_ack = 1'b0;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        settle();
        chk("rst_dout",  32'(bus.d_out),     32'h0);
        chk("rst_done",  32'(bus.rx_done),   32'h0);
        chk("rst_valid", 32'(bus.rx_valid),  32'h0);
        chk("rst_ferr",  32'(bus.frame_err), 32'h0);
        chk("rst_ovr",   32'(bus.overrun),   32'h0);
        cmp_on = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Good frame 0xA5
        dc = done_cnt;
        send_frame(8'hA5, 1'b1);
        idle(2);
        settle();
        chk("t1_dout",  32'(bus.d_out),     32'hA5);
        chk("t1_valid", 32'(bus.rx_valid),  32'h1);
        chk("t1_ferr",  32'(bus.frame_err), 32'h0);
        chk("t1_pulses", 32'(done_cnt - dc), 32'd1);

        // Short low glitch must not produce a frame
        dc = done_cnt;
        wait_tick();
        #1 bus.rx = 1'b0;
        repeat (4) wait_tick();
        #1 bus.rx = 1'b1;
        idle(30);
        settle();
        chk("t2_pulses", 32'(done_cnt - dc), 32'd0);
        chk("t2_dout",   32'(bus.d_out),     32'hA5);
        pulse_ack();
        settle();
        chk("ack_valid", 32'(bus.rx_valid), 32'h0);

        // Framing error, then a good frame clears it
        send_frame(8'h3C, 1'b0);
        idle(2);
        settle();
        chk("t3_dout", 32'(bus.d_out),     32'h3C);
        chk("t3_ferr", 32'(bus.frame_err), 32'h1);
        send_frame(8'h01, 1'b1);
        idle(2);
        settle();
        chk("t3b_dout", 32'(bus.d_out),     32'h01);
        chk("t3b_ferr", 32'(bus.frame_err), 32'h0);
        pulse_ack();

        // Overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(2);
        settle();
        chk("t4_ovr",  32'(bus.overrun), 32'h1);
        chk("t4_dout", 32'(bus.d_out),   32'h22);
        pulse_ack();
        settle();
        chk("t4_valid_clr", 32'(bus.rx_valid), 32'h0);
        chk("t4_ovr_clr",   32'(bus.overrun),  32'h0);

        // Reset during data bit 3 of 0xFF
        send_frame(8'h77, 1'b1);
        idle(2);
        wait_tick();
        #1 bus.rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (OS) wait_tick();
            #1 bus.rx = 1'b1;
        end
        repeat (OS / 2) wait_tick();
        #1 rst_n = 1'b0;
        @(posedge clk);
        settle();
        chk("t5_dout",  32'(bus.d_out),     32'h0);
        chk("t5_valid", 32'(bus.rx_valid),  32'h0);
        chk("t5_ferr",  32'(bus.frame_err), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(OS * 6);
        send_frame(8'h5A, 1'b1);
        idle(2);
        settle();
        chk("t5_next", 32'(bus.d_out), 32'h5A);
        pulse_ack();

        // Back-to-back frames
        dc = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(2);
        settle();
        chk("t6_pulses", 32'(done_cnt - dc), 32'd3);
        chk("t6_dout",   32'(bus.d_out),     32'h55);
        chk("t6_ferr",   32'(bus.frame_err), 32'h0);
        pulse_ack();

        random_phase(20);
        idle(4);
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
